// File: rtl/my_reg_if.sv
// ---------------------------------------------------------------------------
// my_reg_if -- register-file access bus.
//   addr   : register index for the current transfer
//   wdata  : write data
//   write  : write strobe, one transfer per cycle while high
//   read   : read strobe, one transfer per cycle while high
//   rdata  : registered read data, returned one cycle after the read strobe
//   rvalid : one-cycle pulse marking rdata as the result of a read
//   err    : one-cycle pulse flagging an out-of-range access
// master drives the strobes; slave (the register file) drives the response.
// ---------------------------------------------------------------------------
interface my_reg_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              write;
  logic              read;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              err;

  modport master (
    output addr, wdata, write, read,
    input  rdata, rvalid, err
  );

  modport slave (
    input  addr, wdata, write, read,
    output rdata, rvalid, err
  );
endinterface

// File: rtl/my_reg.sv
// ---------------------------------------------------------------------------
// my_reg -- small read/write register file with a one-cycle read latency.
//   clk : single clock, all state changes on the rising edge
//   rst : synchronous, active-high reset; clears registers and outputs
//   bus : my_reg_if slave port (addr/wdata/write/read in, rdata/rvalid/err out)
// Accesses with addr >= NUM_REGS are rejected: writes are dropped, reads
// return zero, and a single err pulse follows the offending cycle.
// ---------------------------------------------------------------------------
module my_reg #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8
) (
  input  logic     clk,
  input  logic     rst,
  my_reg_if.slave  bus
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              err_q;

  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign in_range = (32'(bus.addr) < 32'(NUM_REGS));
  assign idx      = bus.addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is reset explicitly because every register
      // must read back as zero after reset; this costs a reset path per bit.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignment means a read in the same cycle as a
      // write to the same register sees the old value, which is the intended
      // read-before-write behaviour.
      if (bus.write && in_range) begin
        regs[idx] <= bus.wdata;
      end
      if (bus.read) begin
        rdata_q <= in_range ? regs[idx] : '0;
      end
      rvalid_q <= bus.read;
      // read and write share one address, so a combined bad access gives
      // exactly one err pulse.
      err_q    <= (bus.read || bus.write) && !in_range;
    end
  end

  assign bus.rdata  = rdata_q;
  // A read completing in the same cycle reset arrives is discarded.
  assign bus.rvalid = rvalid_q && !rst;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_my_reg.sv
// ---------------------------------------------------------------------------
// tb_my_reg -- self-checking bench for my_reg (NUM_REGS=8, DATA_W=16,
// ADDR_W=8). Every driven cycle pushes the expected response for the next
// cycle onto a scoreboard; a monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_my_reg;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 8;

  typedef struct {
    int                due;
    logic              rvalid;
    logic              err;
    logic [DATA_W-1:0] rdata;
    string             lbl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t              sb[$];
  logic [DATA_W-1:0] model [NUM_REGS];
  logic [DATA_W-1:0] m_rdata = '0;

  my_reg_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  my_reg #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: compares the response due in the current cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: response for cycle %0d never compared (now %0d)", e.lbl, e.due, cyc);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if ({bus.rvalid, bus.err, bus.rdata} !== {e.rvalid, e.err, e.rdata}) begin
        n_bad++;
        $display("FAIL %s (cycle %0d): got rvalid=%b err=%b rdata=%h, expected rvalid=%b err=%b rdata=%h",
                 e.lbl, cyc, bus.rvalid, bus.err, bus.rdata, e.rvalid, e.err, e.rdata);
      end
    end
  end

  // Drives one cycle of stimulus (called just after a rising edge), records
  // the expected response for the following cycle, then advances one cycle.
  task automatic drive(input bit rs, input bit r, input bit w,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                       input string lbl);
    exp_t e;
    bit   oor;
    rst       = rs;
    bus.read  = r;
    bus.write = w;
    bus.addr  = a;
    bus.wdata = wd;
    e.due = cyc + 1;
    e.lbl = lbl;
    if (rs) begin
      // A read whose result is due in this reset cycle is dropped.
      if (sb.size() > 0 && sb[sb.size()-1].due == cyc) sb[sb.size()-1].rvalid = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      m_rdata  = '0;
      e.rvalid = 1'b0;
      e.err    = 1'b0;
    end else begin
      oor      = (int'(a) >= NUM_REGS);
      e.rvalid = r;
      e.err    = (r || w) && oor;
      if (r) m_rdata = oor ? '0 : model[a];
      if (w && !oor) model[a] = wd;
    end
    e.rdata = m_rdata;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string lbl);
    drive(1'b0, 1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 65535), lbl);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input string lbl);
    drive(1'b0, 1'b1, 1'b0, a, $urandom_range(0, 65535), lbl);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input string lbl);
    drive(1'b0, 1'b0, 1'b1, a, d, lbl);
  endtask

  task automatic test_reset();
    bus.read  = 1'b0;
    bus.write = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.rdata !== '0) begin
      n_bad++; $display("FAIL reset_rdata: got %h, expected 0000", bus.rdata);
    end
    n_cmp++;
    if (bus.rvalid !== 1'b0) begin
      n_bad++; $display("FAIL reset_rvalid: got %b, expected 0", bus.rvalid);
    end
    n_cmp++;
    if (bus.err !== 1'b0) begin
      n_bad++; $display("FAIL reset_err: got %b, expected 0", bus.err);
    end
    drive(1'b1, 1'b0, 1'b0, '0, '0, "reset_hold");
    idle("reset_release");
  endtask

  task automatic test_read_all_zero();
    for (int i = 0; i < NUM_REGS; i++) rd(i[ADDR_W-1:0], "read_zero");
    idle("read_zero_tail");
  endtask

  task automatic test_write_read();
    wr(8'd3, 16'hA5C3, "wr3");
    rd(8'd3, "rd3");
    for (int i = 0; i < NUM_REGS; i++) rd(i[ADDR_W-1:0], "wr3_readback");
  endtask

  task automatic test_read_during_write();
    wr(8'd5, 16'h1234, "wr5");
    drive(1'b0, 1'b1, 1'b1, 8'd5, 16'hBEEF, "rdwr5_old");
    rd(8'd5, "rd5_new");
    idle("rdwr5_tail");
  endtask

  task automatic test_out_of_range();
    wr(8'd8, 16'hFFFF, "wr_oor");
    idle("wr_oor_after");
    for (int i = 0; i < NUM_REGS; i++) rd(i[ADDR_W-1:0], "oor_readback");
    rd(8'd200, "rd_oor");
    drive(1'b0, 1'b1, 1'b1, 8'd255, 16'h5555, "rdwr_oor");
    idle("rdwr_oor_single");
    // rdata must hold across idle cycles until the next read.
    rd(8'd3, "rd3_hold");
    idle("hold1");
    idle("hold2");
    wr(8'd1, 16'h0F0F, "hold_write");
  endtask

  task automatic test_reset_priority();
    for (int i = 0; i < NUM_REGS; i++) begin
      wr(i[ADDR_W-1:0], DATA_W'(16'h1111 * (i + 1)), "fill");
    end
    rd(8'd7, "fill_rd7");
    drive(1'b1, 1'b0, 1'b1, 8'd0, 16'hDEAD, "rst_with_write");
    for (int i = 0; i < NUM_REGS; i++) rd(i[ADDR_W-1:0], "post_rst");
    idle("post_rst_tail");
  endtask

  task automatic test_read_before_reset();
    wr(8'd2, 16'h7E57, "wr2");
    rd(8'd2, "rd_dropped");
    drive(1'b1, 1'b0, 1'b0, '0, '0, "rst_after_rd");
    rd(8'd2, "rd2_cleared");
    idle("drop_tail");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) wr(i[ADDR_W-1:0], DATA_W'(16'hC000 + i * 16'h0101), "b2b_fill");
    for (int i = 0; i < 4; i++) rd(i[ADDR_W-1:0], "b2b_rd");
    idle("b2b_tail");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ADDR_W'($urandom_range(0, NUM_REGS + 1)), DATA_W'($urandom_range(0, 65535)), "random");
    end
    for (int i = 0; i < NUM_REGS; i++) rd(i[ADDR_W-1:0], "random_readback");
    idle("random_tail");
  endtask

  initial begin
    test_reset();
    test_read_all_zero();
    test_write_read();
    test_read_during_write();
    test_out_of_range();
    test_reset_priority();
    test_read_before_reset();
    test_back_to_back();
    test_random();
    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
